// File: rtl/scu_bac_pkg.sv
// scu_bac_pkg: shared types and response codes for the SCU BAC initiator.
// Used by scu_bac_master and any BAC-facing helpers.
package scu_bac_pkg;

  localparam int BAC_ADDR_W = 12;
  localparam int BAC_RSP_W  = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } bac_mst_state_e;

  localparam logic [1:0] BAC_RSP_OK      = 2'b00;
  localparam logic [1:0] BAC_RSP_SLVERR  = 2'b01;
  localparam logic [1:0] BAC_RSP_DECERR  = 2'b10;
  localparam logic [1:0] BAC_RSP_TIMEOUT = 2'b11;

  typedef struct packed {
    logic                  wr;
    logic [BAC_ADDR_W-1:0] address;
    logic [31:0]           write_data;
    logic [3:0]            byte_en;
  } bac_req_t;

endpackage

// File: rtl/scu_bac_master.sv
// scu_bac_master: single-transaction BAC initiator, valid/ready in and out.
// Define SCU_BAC_MASTER_TIMEOUT_EN to abort stalled accesses with code 2'b11.
module scu_bac_master
  import scu_bac_pkg::*;
#(
  parameter int p_bac_reg_offset_address_width = BAC_ADDR_W,
  parameter int p_response_width               = BAC_RSP_W,
  parameter int p_timeout_cycles               = 256
) (
  input  logic                                      clk_i,
  input  logic                                      rst_n_i,
  input  logic                                      req_valid_i,
  output logic                                      req_ready_o,
  input  logic                                      req_wr_i,
  input  logic [p_bac_reg_offset_address_width-1:0] req_address_i,
  input  logic [31:0]                               req_write_data_i,
  input  logic [3:0]                                req_byte_en_i,
  output logic                                      rsp_valid_o,
  input  logic                                      rsp_ready_i,
  output logic [31:0]                               rsp_read_data_o,
  output logic [p_response_width-1:0]               rsp_response_o,
  output logic                                      bac_csb_o,
  output logic                                      bac_wr_o,
  output logic [p_bac_reg_offset_address_width-1:0] bac_address_o,
  output logic [31:0]                               bac_write_data_o,
  output logic [3:0]                                bac_byte_en_o,
  input  logic [31:0]                               bac_read_data_i,
  input  logic                                      bac_ready_i,
  input  logic [p_response_width-1:0]               bac_response_i
);

  if (p_timeout_cycles < 2) begin : g_bad_tmo
    $error("p_timeout_cycles must be at least 2");
  end

  bac_mst_state_e state_q, state_d;
  logic           tmo_hit;
  logic           access_done;

`ifdef SCU_BAC_MASTER_TIMEOUT_EN
  localparam int CW = $clog2(p_timeout_cycles);

  logic [CW-1:0] tmo_cnt_q;

  // Held at zero outside ACCESS so every access starts counting from 0.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tmo_cnt_q <= '0;
    end else if (state_q != ACCESS) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end
  end

  assign tmo_hit = (state_q == ACCESS) && !bac_ready_i &&
                   (tmo_cnt_q == CW'(p_timeout_cycles - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  assign access_done = (state_q == ACCESS) && (bac_ready_i || tmo_hit);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_valid_i) state_d = ACCESS;
      ACCESS:  if (access_done) state_d = RESP;
      RESP:    if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake and chip-select flops follow the next state.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      req_ready_o <= 1'b1;
      rsp_valid_o <= 1'b0;
      bac_csb_o   <= 1'b1;
    end else begin
      req_ready_o <= (state_d == IDLE);
      rsp_valid_o <= (state_d == RESP);
      bac_csb_o   <= (state_d != ACCESS);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      bac_wr_o         <= 1'b0;
      bac_address_o    <= '0;
      bac_write_data_o <= '0;
      bac_byte_en_o    <= '0;
      rsp_read_data_o  <= '0;
      rsp_response_o   <= '0;
    end else begin
      if (state_q == IDLE && req_valid_i) begin
        bac_wr_o         <= req_wr_i;
        bac_address_o    <= req_address_i;
        bac_write_data_o <= req_write_data_i;
        bac_byte_en_o    <= req_byte_en_i;
      end
      if (access_done) begin
        bac_wr_o      <= 1'b0;
        bac_byte_en_o <= '0;
        if (bac_ready_i) begin
          rsp_read_data_o <= bac_wr_o ? 32'h0 : bac_read_data_i;
          rsp_response_o  <= bac_response_i;
        end else begin
          rsp_read_data_o <= 32'h0;
          rsp_response_o  <= p_response_width'(BAC_RSP_TIMEOUT);
        end
      end
    end
  end

endmodule

// File: tb/tb_scu_bac_master.sv
// Randomized scoreboard bench for scu_bac_master with a memory-backed responder.
// Timeout scenarios compile in when SCU_BAC_MASTER_TIMEOUT_EN is defined.
module tb_scu_bac_master;

  localparam int AW  = 12;
  localparam int TMO = 8;
`ifdef SCU_BAC_MASTER_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n_i;
  logic          req_valid_i, req_ready_o, req_wr_i;
  logic [AW-1:0] req_address_i;
  logic [31:0]   req_write_data_i;
  logic [3:0]    req_byte_en_i;
  logic          rsp_valid_o, rsp_ready_i;
  logic [31:0]   rsp_read_data_o;
  logic [1:0]    rsp_response_o;
  logic          bac_csb_o, bac_wr_o;
  logic [AW-1:0] bac_address_o;
  logic [31:0]   bac_write_data_o;
  logic [3:0]    bac_byte_en_o;
  logic [31:0]   bac_read_data_i;
  logic          bac_ready_i;
  logic [1:0]    bac_response_i;

  always #5 clk = ~clk;

  scu_bac_master #(
    .p_bac_reg_offset_address_width(AW),
    .p_response_width(2),
    .p_timeout_cycles(TMO)
  ) dut (
    .clk_i(clk),
    .rst_n_i(rst_n_i),
    .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o),
    .req_wr_i(req_wr_i),
    .req_address_i(req_address_i),
    .req_write_data_i(req_write_data_i),
    .req_byte_en_i(req_byte_en_i),
    .rsp_valid_o(rsp_valid_o),
    .rsp_ready_i(rsp_ready_i),
    .rsp_read_data_o(rsp_read_data_o),
    .rsp_response_o(rsp_response_o),
    .bac_csb_o(bac_csb_o),
    .bac_wr_o(bac_wr_o),
    .bac_address_o(bac_address_o),
    .bac_write_data_o(bac_write_data_o),
    .bac_byte_en_o(bac_byte_en_o),
    .bac_read_data_i(bac_read_data_i),
    .bac_ready_i(bac_ready_i),
    .bac_response_i(bac_response_i)
  );

  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic [3:0]    be;
    int            lat;
    logic [1:0]    rsp;
  } plan_t;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  rsp;
  } exp_t;

  plan_t       plan_q[$];
  exp_t        exp_q[$];
  logic [31:0] rmem [4096];
  logic [31:0] mmem [4096];
  int          checks = 0;
  int          failures = 0;
  int          bp_force = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d,
                                        logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Responder: plays back planned latency/response, backed by rmem.
  initial begin : responder
    plan_t cur;
    bit    in_txn;
    int    cyc;
    in_txn = 0;
    cyc = 0;
    cur = '{wr: 0, addr: '0, data: '0, be: '0, lat: 0, rsp: '0};
    bac_ready_i = 0;
    bac_read_data_i = '0;
    bac_response_i = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n_i) begin
        in_txn = 0;
        bac_ready_i = 0;
        continue;
      end
      if (!bac_csb_o) begin
        if (!in_txn) begin
          if (plan_q.size() == 0) begin
            chk("unplanned_access", 1, 0);
            cur = '{wr: bac_wr_o, addr: bac_address_o, data: bac_write_data_o,
                    be: bac_byte_en_o, lat: 0, rsp: 2'b00};
          end else begin
            cur = plan_q.pop_front();
          end
          in_txn = 1;
          cyc = 0;
        end else begin
          cyc++;
        end
        chk("bac_wr", bac_wr_o, cur.wr);
        chk("bac_addr", bac_address_o, cur.addr);
        chk("bac_wdata", bac_write_data_o, cur.data);
        chk("bac_be", bac_byte_en_o, cur.be);
        chk("no_rsp_in_access", rsp_valid_o, 0);
        bac_ready_i = (cyc == cur.lat);
        bac_response_i = 2'($urandom);
        bac_read_data_i = $urandom;
        if (bac_ready_i) begin
          bac_response_i = cur.rsp;
          bac_read_data_i = rmem[bac_address_o];
          if (bac_wr_o && cur.rsp == 2'b00)
            rmem[bac_address_o] = merge(rmem[bac_address_o],
                                        bac_write_data_o, bac_byte_en_o);
        end
      end else begin
        if (in_txn) begin
          in_txn = 0;
          chk("csb_low_cycles", cyc + 1,
              (TMO_EN && cur.lat >= TMO) ? TMO : cur.lat + 1);
          chk("end_state",
              {rsp_valid_o, bac_wr_o, bac_byte_en_o, bac_address_o},
              {1'b1, 1'b0, 4'h0, cur.addr});
        end
        bac_ready_i = 1'($urandom);
        bac_response_i = 2'($urandom);
        bac_read_data_i = $urandom;
      end
    end
  end

  // Monitor: drives rsp_ready_i, checks hold stability, pops scoreboard.
  initial begin : monitor
    bit          pend;
    logic [31:0] pd;
    logic [1:0]  pr;
    exp_t        e;
    pend = 0;
    pd = '0;
    pr = '0;
    rsp_ready_i = 0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n_i) begin
        pend = 0;
        rsp_ready_i = 0;
        continue;
      end
      chk("req_ready", req_ready_o, bac_csb_o && !rsp_valid_o);
      if (pend) begin
        chk("rsp_valid_hold", rsp_valid_o, 1);
        chk("rsp_data_hold", rsp_read_data_o, pd);
        chk("rsp_code_hold", rsp_response_o, pr);
      end
      if (rsp_valid_o) chk("csb_high_in_resp", bac_csb_o, 1);
      if (bp_force > 0 && rsp_valid_o) begin
        rsp_ready_i = 0;
        bp_force--;
      end else begin
        rsp_ready_i = ($urandom_range(0, 3) != 0);
      end
      pend = 0;
      if (rsp_valid_o && rsp_ready_i) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_data", rsp_read_data_o, e.data);
          chk("rsp_code", rsp_response_o, e.rsp);
        end
      end else if (rsp_valid_o) begin
        pend = 1;
        pd = rsp_read_data_o;
        pr = rsp_response_o;
      end
    end
  end

  task automatic issue(bit wr, logic [AW-1:0] a, logic [31:0] d,
                       logic [3:0] be, int lat, logic [1:0] rsp, bit dropped);
    plan_t p;
    exp_t  e;
    int    n;
    p = '{wr: wr, addr: a, data: d, be: be, lat: lat, rsp: rsp};
    plan_q.push_back(p);
    if (!dropped) begin
      if (TMO_EN && lat >= TMO) begin
        e = '{data: 32'h0, rsp: 2'b11};
      end else if (wr) begin
        e = '{data: 32'h0, rsp: rsp};
        if (rsp == 2'b00) mmem[a] = merge(mmem[a], d, be);
      end else begin
        e = '{data: mmem[a], rsp: rsp};
      end
      exp_q.push_back(e);
    end
    @(negedge clk);
    req_valid_i = 1;
    req_wr_i = wr;
    req_address_i = a;
    req_write_data_i = d;
    req_byte_en_i = be;
    n = 0;
    while (!req_ready_o && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) chk("req_accept_bound", 0, 1);
    @(posedge clk);
  endtask

  task automatic release_req();
    @(negedge clk);
    req_valid_i = 0;
    req_wr_i = 1'($urandom);
    req_address_i = AW'($urandom);
    req_write_data_i = $urandom;
    req_byte_en_i = 4'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) chk("drain_bound", 0, 1);
    repeat (3) @(negedge clk);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    rst_n_i = 0;
    req_valid_i = 0;
    req_wr_i = 0;
    req_address_i = '0;
    req_write_data_i = '0;
    req_byte_en_i = '0;
    for (int i = 0; i < 4096; i++) begin
      rmem[i] = (i * 32'h0101_0101) ^ 32'hDEAD_0000;
      mmem[i] = (i * 32'h0101_0101) ^ 32'hDEAD_0000;
    end
    rmem[12'h018] = 32'hA5A5_0001;
    mmem[12'h018] = 32'hA5A5_0001;
    #12;
    chk("rst_ctrl", {bac_csb_o, req_ready_o, rsp_valid_o, bac_wr_o}, 4'b1100);
    chk("rst_bac_fields", {bac_address_o, bac_byte_en_o}, 0);
    chk("rst_wdata", bac_write_data_o, 0);
    chk("rst_rsp", {rsp_read_data_o, rsp_response_o}, 0);
    @(negedge clk);
    rst_n_i = 1;
    repeat (2) @(negedge clk);

    issue(1, 12'h024, 32'h1234_5678, 4'hF, 2, 2'b00, 0);
    release_req();
    drain();
    issue(0, 12'h018, 32'h0, 4'h0, 0, 2'b00, 0);
    release_req();
    drain();
    issue(0, 12'h030, 32'h0, 4'h0, 1, 2'b10, 0);
    issue(1, 12'h031, 32'hCAFE_F00D, 4'h3, 0, 2'b00, 0);
    release_req();
    drain();
    bp_force = 5;
    issue(0, 12'h005, 32'h0, 4'h0, 1, 2'b01, 0);
    release_req();
    drain();
`ifdef SCU_BAC_MASTER_TIMEOUT_EN
    issue(0, 12'h006, 32'h0, 4'h0, 1000, 2'b00, 0);
    issue(1, 12'h007, 32'h7777_7777, 4'hF, 7, 2'b00, 0);
    issue(1, 12'h008, 32'h8888_8888, 4'hF, 1000, 2'b00, 0);
    issue(0, 12'h008, 32'h0, 4'h0, 0, 2'b00, 0);
`else
    issue(1, 12'h007, 32'h7777_7777, 4'hF, 9, 2'b00, 0);
    issue(0, 12'h007, 32'h0, 4'h0, 0, 2'b00, 0);
`endif
    release_req();
    drain();

    issue(0, 12'h009, 32'h0, 4'h0, 6, 2'b00, 1);
    release_req();
    @(negedge clk);
    rst_n_i = 0;
    #1;
    chk("midrst_ctrl", {bac_csb_o, rsp_valid_o, req_ready_o, bac_wr_o}, 4'b1010);
    chk("midrst_fields", {bac_address_o, bac_byte_en_o}, 0);
    @(negedge clk);
    rst_n_i = 1;
    @(negedge clk);
    issue(0, 12'h009, 32'h0, 4'h0, 1, 2'b00, 0);
    release_req();
    drain();

    for (int i = 0; i < 60; i++) begin
      issue(1'($urandom), AW'($urandom_range(0, 15)), $urandom,
            4'($urandom), TMO_EN ? $urandom_range(0, 11) : $urandom_range(0, 6),
            2'($urandom_range(0, 2)), 0);
      if ($urandom_range(0, 2) == 0) begin
        release_req();
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end
    release_req();
    drain();
    chk("plan_q_empty", plan_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
